// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: byte width and FSM state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Launch FSM of the feeder; encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACTIVE = 2'd1,
        ST_WAIT_DONE   = 2'd2
    } feeder_state_e;

    // Serial transmitter frame phases.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with separate up/down occupancy counter; full/empty derived from count.
// Latency: push visible in count/empty one cycle after the accepting edge; head data read combinationally.
// Backpressure: push ignored while full, pop ignored while empty.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care while unoccupied so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit, CLOCKS_PER_BIT clocks each.
// Latency: start_i sampled in idle -> line drops to start bit the next cycle; done_o pulses after stop.
// Backpressure: start_i ignored while a frame is active (active_o high).
module uart_tx import uart_pkg::*; #(
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start_i,
    input  logic [UART_DATA_W-1:0] send_data_i,
    output logic                   active_o,
    output logic                   done_o,
    output logic                   tx_o
);

    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(UART_DATA_W);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   done_q, done_d;
    logic                   tx_q, tx_d;
    logic                   cnt_last;

    assign cnt_last = (clk_cnt_q == CNT_W'(CLOCKS_PER_BIT - 1));
    assign active_o = (state_q != TX_IDLE);
    assign done_o   = done_q;
    assign tx_o     = tx_q;

    // Frame sequencing: each phase lasts CLOCKS_PER_BIT cycles; data shifts out LSB first.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        done_d    = 1'b0;
        tx_d      = tx_q;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (start_i) begin
                    data_d    = send_data_i;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                if (cnt_last) begin
                    clk_cnt_d = '0;
                    tx_d      = data_q[0];
                    state_d   = TX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_last) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == BIT_W'(UART_DATA_W - 1)) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        data_d    = data_q >> 1;
                        tx_d      = data_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_last) begin
                    clk_cnt_d = '0;
                    done_d    = 1'b1;
                    state_d   = TX_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Frame state registers; line idles high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= TX_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            done_q    <= done_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding uart_tx; optional sticky overflow flag under UART_TX_FEEDER_OVERFLOW_EN.
// Latency: write at edge k -> count after k, launch (pop + tx_start_o) after k+1; relaunch the cycle after tx_done_i.
// Backpressure: writes while full_o are dropped; tx_start_o held until tx_active_i acknowledges.
module uart_tx_feeder import uart_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_en_i,
    input  logic [UART_DATA_W-1:0]     wr_data_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic                       tx_start_o,
    output logic [UART_DATA_W-1:0]     tx_data_o,
    input  logic                       tx_active_i,
    input  logic                       tx_done_i
);

    feeder_state_e          state_q, state_d;
    logic                   tx_start_q, tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_head;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (wr_en_i),
        .push_data_i (wr_data_i),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count_o)
    );

    assign full_o     = fifo_full;
    assign empty_o    = fifo_empty;
    assign busy_o     = ~fifo_empty | (state_q != ST_IDLE);
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

    // Launch FSM: pop the head into tx_data and raise start, hold start until the transmitter goes active.
    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_data_d  = fifo_head;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_ACTIVE;
                end
            end
            ST_WAIT_ACTIVE: begin
                if (tx_active_i) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done_i) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_data_d  = fifo_head;
                        tx_start_d = 1'b1;
                        state_d    = ST_WAIT_ACTIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // FSM and transmitter-facing output registers; reset abandons any byte in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_TX_FEEDER_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // Sticky: any write attempt while the registered full flag is set.
    always_comb begin
        overflow_d = overflow_q | (wr_en_i & fifo_full);
    end

    // Overflow flag register, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule
